// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4, imem request/ready handshake, IF/ID register.
// Optional IF_FETCH_PERF_EN adds saturating fetch/bubble counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] next_pc,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        flush,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc_plus4,
   output logic        if_id_valid
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_cnt,
   output logic [31:0] perf_bubble_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_HOLD
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] pc_q;
   logic [31:0] pc_aligned;
   logic [31:0] ifid_instr_q, ifid_pc4_q;
   logic        ifid_valid_q;
   logic [31:0] hold_instr_q, hold_pc4_q;

   logic        pc_load;
   logic        ifid_load;
   logic [31:0] ifid_instr_nxt, ifid_pc4_nxt;
   logic        ifid_valid_nxt;
   logic        hold_load, hold_clr;

   assign pc_aligned     = next_pc & 32'hFFFF_FFFC;
   assign pc             = pc_q;
   assign pc_plus4       = pc_q + 32'd4;
   assign imem_addr      = pc_q;
   assign imem_req       = (state == ST_FETCH);
   assign if_id_instr    = ifid_instr_q;
   assign if_id_pc_plus4 = ifid_pc4_q;
   assign if_id_valid    = ifid_valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Each register is driven by an explicit load strobe; the strobe's valid bit
   // also distinguishes real instructions from bubbles for the perf counters.
   always_comb begin
      state_nxt      = state;
      pc_load        = 1'b0;
      ifid_load      = 1'b0;
      ifid_instr_nxt = NOP_INSTR;
      ifid_pc4_nxt   = '0;
      ifid_valid_nxt = 1'b0;
      hold_load      = 1'b0;
      hold_clr       = 1'b0;

      if (state != ST_IDLE && flush) begin
         ifid_load = 1'b1;
         pc_load   = 1'b1;
         hold_clr  = 1'b1;
         state_nxt = ST_FETCH;
      end else begin
         case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
               if (imem_ready && !stall) begin
                  ifid_load      = 1'b1;
                  ifid_instr_nxt = imem_rdata;
                  ifid_pc4_nxt   = pc_plus4;
                  ifid_valid_nxt = 1'b1;
                  pc_load        = 1'b1;
               end else if (imem_ready && stall) begin
                  hold_load = 1'b1;
                  state_nxt = ST_HOLD;
               end else if (!stall) begin
                  ifid_load = 1'b1;
               end
            end
            ST_HOLD: begin
               if (!stall) begin
                  ifid_load      = 1'b1;
                  ifid_instr_nxt = hold_instr_q;
                  ifid_pc4_nxt   = hold_pc4_q;
                  ifid_valid_nxt = 1'b1;
                  pc_load        = 1'b1;
                  state_nxt      = ST_FETCH;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else if (pc_load) begin
         pc_q <= pc_aligned;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ifid_instr_q <= NOP_INSTR;
         ifid_pc4_q   <= '0;
         ifid_valid_q <= 1'b0;
      end else if (ifid_load) begin
         ifid_instr_q <= ifid_instr_nxt;
         ifid_pc4_q   <= ifid_pc4_nxt;
         ifid_valid_q <= ifid_valid_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_instr_q <= '0;
         hold_pc4_q   <= '0;
      end else if (hold_clr) begin
         hold_instr_q <= '0;
         hold_pc4_q   <= '0;
      end else if (hold_load) begin
         hold_instr_q <= imem_rdata;
         hold_pc4_q   <= pc_plus4;
      end
   end

`ifdef IF_FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, bubble_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else if (ifid_load) begin
         if (ifid_valid_nxt && fetch_cnt_q != '1)
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (!ifid_valid_nxt && bubble_cnt_q != '1)
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
   end

   assign perf_fetch_cnt  = fetch_cnt_q;
   assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Table-driven directed bench for if_fetch_stage, plus async-reset and perf-counter sequences.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] next_pc;
   logic [31:0] pc, pc_plus4, imem_addr, imem_rdata;
   logic        imem_req, imem_ready, stall, flush;
   logic [31:0] if_id_instr, if_id_pc_plus4;
   logic        if_id_valid;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt, perf_bubble_cnt;
`endif

   if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
      .clk(clk), .rst_n(rst_n), .next_pc(next_pc), .pc(pc), .pc_plus4(pc_plus4),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .stall(stall), .flush(flush),
      .if_id_instr(if_id_instr), .if_id_pc_plus4(if_id_pc_plus4), .if_id_valid(if_id_valid)
`ifdef IF_FETCH_PERF_EN
      , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ready, stl, fl;
      logic [31:0] rdata, npc;
      logic [31:0] e_pc, e_instr, e_pc4;
      logic        e_valid, e_req;
   } vec_t;

   vec_t tbl[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic add(input logic r, s, f, input logic [31:0] rd, np, epc, ei, ep4,
                      input logic ev, er);
      vec_t v;
      v.ready = r; v.stl = s; v.fl = f; v.rdata = rd; v.npc = np;
      v.e_pc = epc; v.e_instr = ei; v.e_pc4 = ep4; v.e_valid = ev; v.e_req = er;
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, s, f, input logic [31:0] rd, np);
      imem_ready = r; stall = s; flush = f; imem_rdata = rd; next_pc = np;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " pc"},        pc, 32'h0);
      chk({tag, " pc_plus4"},  pc_plus4, 32'h4);
      chk({tag, " imem_addr"}, imem_addr, 32'h0);
      chk({tag, " imem_req"},  {31'b0, imem_req}, 32'h0);
      chk({tag, " instr"},     if_id_instr, NOP);
      chk({tag, " ifid_pc4"},  if_id_pc_plus4, 32'h0);
      chk({tag, " valid"},     {31'b0, if_id_valid}, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //    rdy stl fl  rdata          next_pc        e_pc           e_instr        e_pc4          v    req
      add(1, 0, 0, 32'hAAAA_0000, 32'h0000_0004, 32'h0000_0000, NOP,           32'h0000_0000, 0, 1);
      add(1, 0, 0, 32'h1111_0000, 32'h0000_0004, 32'h0000_0004, 32'h1111_0000, 32'h0000_0004, 1, 1);
      add(1, 0, 0, 32'h1111_0004, 32'h0000_0008, 32'h0000_0008, 32'h1111_0004, 32'h0000_0008, 1, 1);
      add(1, 0, 0, 32'h1111_0008, 32'h0000_000C, 32'h0000_000C, 32'h1111_0008, 32'h0000_000C, 1, 1);
      add(1, 0, 0, 32'h1111_000C, 32'h0000_0010, 32'h0000_0010, 32'h1111_000C, 32'h0000_0010, 1, 1);
      add(0, 0, 0, 32'hDEAD_0001, 32'h0000_0014, 32'h0000_0010, NOP,           32'h0000_0000, 0, 1);
      add(1, 0, 0, 32'h1111_0010, 32'h0000_0014, 32'h0000_0014, 32'h1111_0010, 32'h0000_0014, 1, 1);
      add(0, 0, 0, 32'hDEAD_0002, 32'h0000_0018, 32'h0000_0014, NOP,           32'h0000_0000, 0, 1);
      add(1, 0, 0, 32'h1111_0014, 32'h0000_0018, 32'h0000_0018, 32'h1111_0014, 32'h0000_0018, 1, 1);
      add(1, 1, 0, 32'h2002_0005, 32'h0000_001C, 32'h0000_0018, 32'h1111_0014, 32'h0000_0018, 1, 0);
      add(1, 1, 0, 32'hDEAD_0003, 32'h0000_001C, 32'h0000_0018, 32'h1111_0014, 32'h0000_0018, 1, 0);
      add(0, 1, 0, 32'hDEAD_0004, 32'h0000_001C, 32'h0000_0018, 32'h1111_0014, 32'h0000_0018, 1, 0);
      add(1, 0, 0, 32'hDEAD_0005, 32'h0000_001C, 32'h0000_001C, 32'h2002_0005, 32'h0000_001C, 1, 1);
      add(0, 1, 0, 32'hDEAD_0006, 32'h0000_0020, 32'h0000_001C, 32'h2002_0005, 32'h0000_001C, 1, 1);
      add(1, 1, 1, 32'hBAD0_0001, 32'h0000_0103, 32'h0000_0100, NOP,           32'h0000_0000, 0, 1);
      add(1, 0, 0, 32'h1111_0100, 32'h0000_0105, 32'h0000_0104, 32'h1111_0100, 32'h0000_0104, 1, 1);
      add(1, 1, 0, 32'h1111_0104, 32'h0000_0300, 32'h0000_0104, 32'h1111_0100, 32'h0000_0104, 1, 0);
      add(1, 1, 1, 32'hBAD0_0002, 32'h0000_0200, 32'h0000_0200, NOP,           32'h0000_0000, 0, 1);
      add(0, 0, 0, 32'hDEAD_0007, 32'h0000_0300, 32'h0000_0200, NOP,           32'h0000_0000, 0, 1);
      add(1, 0, 0, 32'h1111_0200, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'h1111_0200, 32'h0000_0204, 1, 1);
      add(1, 0, 0, 32'h1111_FFFC, 32'h0000_0000, 32'h0000_0000, 32'h1111_FFFC, 32'h0000_0000, 1, 1);

      rst_n = 1'b0;
      drive(0, 0, 0, 32'h0, 32'h0);
      step();
      step();
      chk_reset_vals("reset");
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         drive(tbl[i].ready, tbl[i].stl, tbl[i].fl, tbl[i].rdata, tbl[i].npc);
         step();
         chk($sformatf("r%0d pc", i),        pc, tbl[i].e_pc);
         chk($sformatf("r%0d imem_addr", i), imem_addr, tbl[i].e_pc);
         chk($sformatf("r%0d pc_plus4", i),  pc_plus4, tbl[i].e_pc + 32'd4);
         chk($sformatf("r%0d instr", i),     if_id_instr, tbl[i].e_instr);
         chk($sformatf("r%0d ifid_pc4", i),  if_id_pc_plus4, tbl[i].e_pc4);
         chk($sformatf("r%0d valid", i),     {31'b0, if_id_valid}, {31'b0, tbl[i].e_valid});
         chk($sformatf("r%0d imem_req", i),  {31'b0, imem_req}, {31'b0, tbl[i].e_req});
         if (i == 19) chk("wrap pc_plus4", pc_plus4, 32'h0000_0000);
      end

      // Enter HOLD, then assert reset between clock edges.
      drive(1, 1, 0, 32'h5555_0001, 32'h0000_0004);
      step();
      chk("hold imem_req", {31'b0, imem_req}, 32'h0);
      chk("hold pc", pc, 32'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_vals("async");
      drive(1, 0, 0, 32'h5555_0002, 32'h0000_0008);
      step();
      chk_reset_vals("in_reset");
      rst_n = 1'b1;
      step();
      chk("idle pc", pc, 32'h0);
      chk("idle instr", if_id_instr, NOP);
      chk("idle valid", {31'b0, if_id_valid}, 32'h0);
      chk("idle->fetch req", {31'b0, imem_req}, 32'h1);

`ifdef IF_FETCH_PERF_EN
      chk("perf fetch reset", perf_fetch_cnt, 32'h0);
      chk("perf bubble reset", perf_bubble_cnt, 32'h0);
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 0, 32'h6666_0000 + k, 32'h0000_0100 + 32'(k) * 4);
         step();
      end
      for (int k = 0; k < 2; k++) begin
         drive(0, 0, 0, 32'h0, 32'h0);
         step();
      end
      drive(1, 1, 1, 32'h7777_0000, 32'h0000_0400);
      step();
      chk("perf fetch cnt", perf_fetch_cnt, 32'd5);
      chk("perf bubble cnt", perf_bubble_cnt, 32'd3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage that sits directly downstream of the 32-bit next-PC select mux.
- It registers the mux output as the program counter and generates PC+4, which returns to the mux's in_0 input.
- It drives a request/ready instruction-memory handshake and fills the IF/ID pipeline register.
- It honours stall (hold) and flush (redirect) commands from the hazard/branch logic.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- next_pc  input  32  output of the next-PC mux (PC+4 or branch/jump target).
- pc  output  32  current PC register.
- pc_plus4  output  32  combinational pc + 4, fed to the next-PC mux in_0.
- imem_req  output  1  fetch request.
- imem_addr  output  32  fetch address, equal to pc.
- imem_rdata  input  32  instruction word, valid when imem_ready=1.
- imem_ready  input  1  read complete for the address presented this cycle.
- stall  input  1  hold PC and IF/ID.
- flush  input  1  redirect: squash IF/ID, load next_pc.
- if_id_instr  output  32  IF/ID instruction.
- if_id_pc_plus4  output  32  IF/ID PC+4.
- if_id_valid  output  1  IF/ID holds a real instruction.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - pc=RESET_PC, imem_req=0, if_id_instr=NOP_INSTR, if_id_pc_plus4=0, if_id_valid=0.
  - Hold register cleared; state=IDLE.
- pc_plus4 = pc + 4, modulo 2^32 (32'hFFFF_FFFC gives 0). imem_addr = pc at all times.
- PC loads always take next_pc with bits [1:0] forced to 2'b00.
- State IDLE:
  - imem_req=0.
  - Goes to FETCH on the first clock edge after rst_n deasserts.
- State FETCH: imem_req=1.
  - imem_ready=1 and stall=0: IF/ID <= {imem_rdata, pc_plus4, valid=1}; pc <= next_pc; stay in FETCH. Throughput is one instruction per cycle when memory is zero-wait.
  - imem_ready=1 and stall=1: capture imem_rdata and pc_plus4 into the hold register; IF/ID unchanged; pc unchanged; go to HOLD.
  - imem_ready=0 and stall=0: IF/ID <= bubble (NOP_INSTR, pc_plus4 field 0, valid=0); pc unchanged.
  - imem_ready=0 and stall=1: IF/ID and pc unchanged.
- State HOLD: imem_req=0.
  - stall=1: everything holds.
  - stall=0: IF/ID <= {hold instr, hold pc_plus4, valid=1}; pc <= next_pc; go to FETCH.
- flush=1 overrides stall and imem_ready, from any state except IDLE:
  - IF/ID <= bubble; pc <= next_pc; hold register discarded; state <= FETCH.
  - Any imem_rdata returned in the same cycle is dropped.
- Memory contract: the request may be withdrawn or its address changed in any cycle. imem_ready refers only to the address presented in that cycle. No outstanding-request tracking.
- Reset asserted mid-fetch or mid-HOLD aborts immediately to the reset values.
- IF/ID, pc and hold register never change when the state is IDLE.

Optional Feature:
- Macro: IF_FETCH_PERF_EN.
- Defined: adds two outputs, perf_fetch_cnt[31:0] and perf_bubble_cnt[31:0].
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
  - fetch_cnt increments on every IF/ID load with valid=1.
  - bubble_cnt increments on every IF/ID load with a bubble, including flushes.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Reset then zero-wait memory (imem_ready=1 every cycle, next_pc=pc_plus4, RESET_PC=0) -> pc sequence 0,4,8,C; if_id_pc_plus4 4,8,C,10; if_id_valid=1 from the second edge after reset release.
- Two-cycle memory (ready every other cycle) at pc=32'h10 -> one bubble (valid=0, instr=NOP) between instructions; pc advances only on ready cycles.
- Stall asserted for 3 cycles on a ready cycle with rdata=32'h2002_0005 -> state HOLD, imem_req=0, IF/ID and pc frozen. After stall drops, IF/ID=32'h2002_0005 with valid=1 on the next edge and pc=next_pc.
- Flush with stall=1 and imem_ready=1, next_pc=32'h0000_0103 -> pc=32'h0000_0100, IF/ID bubble, rdata discarded, state FETCH.
- pc=32'hFFFF_FFFC -> pc_plus4=32'h0000_0000. Async reset asserted mid-HOLD -> all outputs at reset values before the next clock edge.
- With IF_FETCH_PERF_EN: 5 valid loads plus 2 bubbles plus 1 flush -> fetch_cnt=5, bubble_cnt=3.
